// File: rtl/pattern_pwm_if.sv
// rtl/pattern_pwm_if.sv - start/pattern request and serial output bundle for pattern_pwm
interface pattern_pwm_if #(
  parameter int _PAT_WIDTH = 16
);
  logic                  pwm_en;
  logic [7:0]            duty_num;
  logic [_PAT_WIDTH-1:0] PAT;
  logic                  pwm_out;
  logic                  busy;
  logic                  valid;

  modport master (
    output pwm_en, duty_num, PAT,
    input  pwm_out, busy, valid
  );

  modport slave (
    input  pwm_en, duty_num, PAT,
    output pwm_out, busy, valid
  );
endinterface

// File: rtl/pattern_pwm.sv
// rtl/pattern_pwm.sv - serialises a latched pattern MSB first, each bit held duty_num+1 clocks
module pattern_pwm #(
  parameter int _PAT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  pattern_pwm_if.slave  bus
);
  localparam int BW = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                r_state;
  logic [_PAT_WIDTH-1:0] r_pat;
  logic [7:0]            r_duty;
  logic [7:0]            r_hold;
  logic [BW-1:0]         r_bit;
  logic                  r_pwm_out;
  logic                  r_busy;
  logic                  r_valid;

  state_t                w_state;
  logic [_PAT_WIDTH-1:0] w_pat;
  logic [7:0]            w_duty;
  logic [7:0]            w_hold;
  logic [BW-1:0]         w_bit;
  logic                  w_pwm_out;
  logic                  w_busy;
  logic                  w_valid;

  // Outputs are computed for the next state and registered, so they never see inputs combinationally
  always_comb begin
    w_state   = r_state;
    w_pat     = r_pat;
    w_duty    = r_duty;
    w_hold    = r_hold;
    w_bit     = r_bit;
    w_pwm_out = 1'b0;
    w_busy    = 1'b0;
    w_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.pwm_en) begin
          w_state   = RUN;
          w_pat     = bus.PAT;
          w_duty    = bus.duty_num;
          w_hold    = 8'd0;
          w_bit     = BW'(_PAT_WIDTH - 1);
          w_pwm_out = bus.PAT[_PAT_WIDTH-1];
          w_busy    = 1'b1;
        end
      end
      RUN: begin
        w_busy    = 1'b1;
        w_pwm_out = r_pwm_out;
        if (r_hold == r_duty) begin
          w_hold = 8'd0;
          if (r_bit == '0) begin
            w_state   = DONE;
            w_busy    = 1'b0;
            w_pwm_out = 1'b0;
            w_valid   = 1'b1;
          end else begin
            w_bit     = r_bit - BW'(1);
            w_pwm_out = r_pat[w_bit];
          end
        end else begin
          w_hold = r_hold + 8'd1;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_duty    <= 8'd0;
      r_hold    <= 8'd0;
      r_bit     <= '0;
      r_pwm_out <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_pat     <= w_pat;
      r_duty    <= w_duty;
      r_hold    <= w_hold;
      r_bit     <= w_bit;
      r_pwm_out <= w_pwm_out;
      r_busy    <= w_busy;
      r_valid   <= w_valid;
    end
  end

  assign bus.pwm_out = r_pwm_out;
  assign bus.busy    = r_busy;
  assign bus.valid   = r_valid;
endmodule

// File: tb/tb_pattern_pwm.sv
// tb/tb_pattern_pwm.sv - randomized and directed bench for pattern_pwm against a queue model
module tb_pattern_pwm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  // expected {pwm_out, busy, valid} per clock
  logic [2:0] exp_q[$];

  pattern_pwm_if #(._PAT_WIDTH(16)) bus ();

  pattern_pwm #(._PAT_WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] outs();
    return {bus.pwm_out, bus.busy, bus.valid};
  endfunction

  task automatic push_burst(input logic [15:0] pat, input logic [7:0] duty);
    for (int b = 15; b >= 0; b--)
      for (int k = 0; k <= int'(duty); k++)
        exp_q.push_back({pat[b], 1'b1, 1'b0});
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b000);
  endtask

  task automatic run_q(input string tag, input int en_cycles, input bit disturb,
                       input logic [15:0] pat, input logic [7:0] duty);
    int i;
    bus.PAT      = pat;
    bus.duty_num = duty;
    bus.pwm_en   = 1'b1;
    i = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      check(tag, 32'(outs()), 32'(exp_q.pop_front()));
      if (i + 1 >= en_cycles) bus.pwm_en = 1'b0;
      if (disturb && i == 5) begin
        bus.PAT      = ~pat;
        bus.duty_num = duty ^ 8'h5A;
        bus.pwm_en   = 1'b1;
      end
      i++;
    end
    bus.pwm_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("idle", 32'(outs()), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [7:0]  duty;
    int          len;

    bus.pwm_en   = 1'b0;
    bus.duty_num = 8'd0;
    bus.PAT      = 16'h0;
    #1;
    check("reset_state", 32'(outs()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 32'(outs()), 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    push_burst(16'hAAAA, 8'd0);
    run_q("aaaa_d0", 1, 1'b0, 16'hAAAA, 8'd0);
    push_burst(16'hCCCC, 8'd1);
    run_q("cccc_d1", 3, 1'b0, 16'hCCCC, 8'd1);
    push_burst(16'hFFFF, 8'd2);
    run_q("ffff_d2", 2, 1'b0, 16'hFFFF, 8'd2);

    push_burst(16'hB38E, 8'd1);
    run_q("mid_change", 1, 1'b1, 16'hB38E, 8'd1);
    idle_cycles(2);

    // pwm_en held through DONE restarts once the FSM is back in IDLE
    len = 16 * 2;
    push_burst(16'h5A3C, 8'd1);
    push_burst(16'h5A3C, 8'd1);
    run_q("held_en", len + 3, 1'b0, 16'h5A3C, 8'd1);
    idle_cycles(2);

    pat = 16'hFFFF;
    bus.PAT      = pat;
    bus.duty_num = 8'd3;
    bus.pwm_en   = 1'b1;
    @(posedge clk); #1;
    check("rst_pre", 32'(outs()), 32'b110);
    bus.pwm_en = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rst_pre_busy", 32'(outs()), 32'b110);
    rst = 1'b1;
    #1;
    check("rst_async", 32'(outs()), 32'd0);
    @(posedge clk); #1;
    check("rst_hold", 32'(outs()), 32'd0);
    rst = 1'b0;
    idle_cycles(4);
    push_burst(16'h1234, 8'd2);
    run_q("after_rst", 1, 1'b0, 16'h1234, 8'd2);

    for (int t = 0; t < 10; t++) begin
      pat  = 16'($urandom);
      duty = 8'($urandom_range(0, 5));
      push_burst(pat, duty);
      run_q("rand", int'($urandom_range(1, 4)), t[0], pat, duty);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    push_burst(16'h8001, 8'd255);
    run_q("d255_8001", 2, 1'b0, 16'h8001, 8'd255);
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pattern_pwm.md
PATTERN_PWM -- requirements
Module: pattern_pwm

Interface
REQ-001 SHALL provide parameter _PAT_WIDTH, default 16: number of pattern bits shifted out per burst (minimum 2).
REQ-002 SHALL provide port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL provide port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL provide port pwm_en, input, 1: start request, sampled each rising edge.
REQ-005 SHALL provide port duty_num, input, 8: hold count; each pattern bit lasts duty_num+1 clocks.
REQ-006 SHALL provide port PAT, input, _PAT_WIDTH: pattern to emit, MSB first.
REQ-007 SHALL provide port pwm_out, output, 1: serial pattern output, registered.
REQ-008 SHALL provide port busy, output, 1: high while a burst is being emitted.
REQ-009 SHALL provide port valid, output, 1: one-clock pulse marking burst completion.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE, SHALL hold pwm_out=0, busy=0 and valid=0.
REQ-012 In IDLE, pwm_en=1 at an edge SHALL latch PAT and duty_num into internal registers and enter RUN.
REQ-013 Later changes on PAT and duty_num SHALL have no effect on a burst in progress.
REQ-014 In the first RUN cycle (one clock after pwm_en is sampled), pwm_out SHALL equal latched PAT[_PAT_WIDTH-1] and busy SHALL be 1.
REQ-015 SHALL hold each bit on pwm_out for exactly duty_num+1 clocks, using an 8-bit hold counter that counts 0..duty_num, then advance to the next lower bit index.
REQ-016 SHALL track the current bit with a counter of width $clog2(_PAT_WIDTH).
REQ-017 After bit 0 has been held for its full duration, SHALL enter DONE.
REQ-018 busy SHALL be 1 for exactly _PAT_WIDTH*(duty_num+1) consecutive clocks.
REQ-019 In DONE (one cycle), SHALL output valid=1, busy=0 and pwm_out=0, then return to IDLE.
REQ-020 duty_num=0 SHALL give one clock per bit; duty_num=255 SHALL give 256 clocks per bit with no counter overflow.
REQ-021 pwm_en SHALL be ignored in RUN and DONE: no restart and no re-latch.
REQ-022 pwm_en held high continuously SHALL start a new burst on the first IDLE edge after DONE.
REQ-023 A multi-cycle pwm_en pulse SHALL start only one burst.
REQ-024 All outputs SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-025 While rst=1, SHALL immediately force state=IDLE, pwm_out=0, busy=0, valid=0, and clear all counters and latched registers, independent of clk.
REQ-026 Reset asserted mid-burst SHALL abort the burst with no valid pulse.
REQ-027 After rst deasserts, the first start SHALL be accepted on the first edge with pwm_en=1.

Verification
REQ-028 duty_num=0, PAT=16'hAAAA, 1-clock pwm_en pulse -> pwm_out 1,0,1,0,... one clock per bit; busy high 16 clocks; single valid pulse the next clock.
REQ-029 duty_num=1, PAT=16'hCCCC -> pwm_out 1,1,1,1,0,0,0,0,... repeating (each bit 2 clocks); busy high 32 clocks; one valid pulse.
REQ-030 duty_num=2, PAT=16'hFFFF -> pwm_out high for 48 consecutive clocks; busy high 48 clocks; valid pulses with pwm_out=0.
REQ-031 Change PAT and duty_num and pulse pwm_en mid-burst -> output continues from the originally latched values; exactly one valid pulse.
REQ-032 Assert rst mid-burst -> outputs go 0 immediately, no valid pulse; a new burst after release runs normally.
REQ-033 duty_num=255, PAT=16'h8001 -> pwm_out high 256 clocks, low 14*256 clocks, high 256 clocks; busy high 4096 clocks.
